step_gate_generator: RTL

Downstream consumer of the sequencer stepper. Watches the stepper's `STEP_NUM` output and holds a programmable on/off pattern per track and per step. On every step advance it fires a one-cycle trigger and a timed gate on each track whose pattern bit is set for the new step. Its outputs drive the voice/envelope stages.

---
 rtl/step_seq_pkg.sv | 11 +
 rtl/gate_timer.sv | 42 ++++
 rtl/step_gate_generator.sv | 91 +++++++++
 3 files changed

// File: rtl/step_seq_pkg.sv
// Shared sequencer definitions: step index width, "no step" sentinel, default pattern length.
package step_seq_pkg;

  localparam int unsigned STEP_W            = 4;
  localparam int unsigned DEFAULT_NUM_STEPS = 8;

  typedef logic [STEP_W-1:0] step_t;

  localparam step_t STEP_NONE = step_t'(4'hF);

endpackage

// File: rtl/gate_timer.sv
// Per-track gate timer: one-cycle trigger flop plus a load/decrement gate counter.
module gate_timer #(
  parameter int unsigned GATE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [GATE_W-1:0] len,
  output logic              trig,
  output logic              gate
);

  logic [GATE_W-1:0] count_q;
  logic [GATE_W-1:0] count_d;

  // Next count: cleared when stopped, reloaded on a trigger, otherwise counts down to zero.
  always_comb begin
    count_d = count_q;
    if (!enable) begin
      count_d = '0;
    end else if (load) begin
      count_d = len;
    end else if (count_q != '0) begin
      count_d = count_q - GATE_W'(1);
    end
  end

  // Counter, registered gate level (from the next count, so it tracks the counter exactly) and trigger pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      gate    <= 1'b0;
      trig    <= 1'b0;
    end else begin
      count_q <= count_d;
      gate    <= (count_d != '0);
      trig    <= enable & load;
    end
  end

endmodule

// File: rtl/step_gate_generator.sv
// Step-driven trigger/gate generator: pattern store, write decode, advance detection and per-track timers.
module step_gate_generator
  import step_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS  = DEFAULT_NUM_STEPS,
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned GATE_W     = 8
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic [STEP_W-1:0]             STEP_NUM,
  input  logic [GATE_W-1:0]             GATE_LEN,
  input  logic                          WR_EN,
  input  logic [$clog2(NUM_TRACKS)-1:0] WR_TRACK,
  input  logic [$clog2(NUM_STEPS)-1:0]  WR_STEP,
  input  logic                          WR_DATA,
  output logic [NUM_TRACKS-1:0]         TRIG,
  output logic [NUM_TRACKS-1:0]         GATE,
  output logic                          HIT
);

  localparam int unsigned TRACK_W = $clog2(NUM_TRACKS);
  localparam int unsigned IDX_W   = $clog2(NUM_STEPS);

  logic [NUM_STEPS-1:0]  pattern_q [NUM_TRACKS];
  step_t                 prev_step_q;
  logic [IDX_W-1:0]      step_idx_c;
  logic                  advance_c;
  logic [NUM_TRACKS-1:0] fire_c;

  // Advance detection: a new in-range step while running; the pattern read sees pre-write contents.
  always_comb begin
    step_idx_c = STEP_NUM[IDX_W-1:0];
    advance_c  = ENABLE && (STEP_NUM < STEP_W'(NUM_STEPS)) && (STEP_NUM != prev_step_q);
    fire_c     = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      fire_c[t] = advance_c & pattern_q[t][step_idx_c];
    end
  end

  // Last accepted step; forgotten on stop so a restart retriggers the current step.
  always_ff @(posedge CLOCK) begin
    if (RESET || !ENABLE) begin
      prev_step_q <= STEP_NONE;
    end else if (advance_c) begin
      prev_step_q <= STEP_NUM;
    end
  end

  // Pattern storage and write decode; indices with no matching cell are dropped.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        pattern_q[t] <= '0;
      end
    end else if (WR_EN) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        for (int s = 0; s < NUM_STEPS; s++) begin
          if ((WR_TRACK == TRACK_W'(t)) && (WR_STEP == IDX_W'(s))) begin
            pattern_q[t][s] <= WR_DATA;
          end
        end
      end
    end
  end

  // Any-track hit pulse, aligned with the per-track trigger flops.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      HIT <= 1'b0;
    end else begin
      HIT <= ENABLE & (|fire_c);
    end
  end

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
    gate_timer #(
      .GATE_W (GATE_W)
    ) u_gate_timer (
      .clk    (CLOCK),
      .reset  (RESET),
      .enable (ENABLE),
      .load   (fire_c[t]),
      .len    (GATE_LEN),
      .trig   (TRIG[t]),
      .gate   (GATE[t])
    );
  end

endmodule
